mem_arb: RTL and testbench
==========================

MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter AW, default 9, word-address width toward DATAMEM.
REQ-002 Parameter DW, default 32, data width.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 m0_req  input  1  CPU data-port access request, level held until granted.
REQ-006 m0_we  input  1  CPU write (1) / read (0), valid with m0_req.
REQ-007 m0_addr  input  AW  CPU word address.
REQ-008 m0_wdata  input  DW  CPU write data.
REQ-009 m0_gnt  output  1  CPU access accepted this cycle.
REQ-010 m0_rvalid  output  1  CPU read data valid.
REQ-011 m0_rdata  output  DW  CPU read data.
REQ-012 m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata shall mirror REQ-005..REQ-011 for the loader/test port.
REQ-013 mem_wen  output  1  DATAMEM write enable.
REQ-014 mem_addr  output  AW  DATAMEM address.
REQ-015 mem_din  output  DW  DATAMEM write data.
REQ-016 mem_dout  input  DW  DATAMEM combinational read data.
REQ-017 stall  output  1  high when m0_req is high and m0_gnt is low.

Function
REQ-018 One access per cycle; gnt combinational in the cycle it is issued; at most one of m0_gnt/m1_gnt high.
REQ-019 Only one requester: it is granted the same cycle.
REQ-020 Both requesting: port named by priority pointer ptr wins; loser's gnt low, loser must hold request.
REQ-021 ptr register: after any cycle where both request, ptr flips to the losing port; otherwise unchanged.
REQ-022 Granted port drives mem_addr/mem_din; mem_wen = gnt & we; write commits at that clock edge.
REQ-023 No grant: mem_wen = 0, mem_addr/mem_din = 0.
REQ-024 Granted read: mem_dout captured into rdata register at that edge; owning port's rvalid high exactly the next cycle for one cycle; rdata holds value until next captured read.
REQ-025 Back-to-back reads to same port: rvalid high on consecutive cycles, data in grant order.
REQ-026 Same-address write on one port and read on the other in one cycle: serialized by ptr; read granted second returns new data.
REQ-027 Write grants never raise rvalid.
REQ-028 Worst-case wait for a held request: 1 cycle (no starvation).

Reset
REQ-029 Asynchronous assertion: ptr=0 (port0 priority), m0/m1_rvalid=0, m0/m1_rdata=0, performance counters=0.
REQ-030 Reset mid-read: pending rvalid discarded; no rvalid after reset release until a new grant.
REQ-031 During reset mem_wen shall be 0 regardless of requests.

Configuration
REQ-032 Macro MEM_ARB_PERF_EN: when defined, adds outputs perf_gnt0[15:0], perf_gnt1[15:0], perf_conflict[15:0], counting grants per port and both-request cycles, saturating at 16'hFFFF.
REQ-033 Without MEM_ARB_PERF_EN: those ports and counters absent; arbitration behaviour identical.

Structure
REQ-034 Shared package holds AW/DW defaults, port-index constants PORT_CPU=0/PORT_LD=1, counter width 16.
REQ-035 One sub-module natural: arb_rr2 (2-way round-robin grant + ptr register); datapath mux and read-return register in mem_arb.

Verification
REQ-036 Reset, m0 read addr 9'h004 (mem holds 32'h1234_5678) -> m0_gnt same cycle, next cycle m0_rvalid=1, m0_rdata=32'h1234_5678.
REQ-037 Both request every cycle from reset -> grants alternate 0,1,0,1; stall high on cycles 2,4.
REQ-038 m1 writes 32'hDEAD_BEEF to 9'h010 while m0 reads 9'h010, ptr=1 -> m1 granted first, m0 reads 32'hDEAD_BEEF one cycle later.
REQ-039 rst_n low one cycle after a read grant -> no rvalid, rdata=0, ptr=0.
REQ-040 With MEM_ARB_PERF_EN, 70000 m0-only grants -> perf_gnt0=16'hFFFF, perf_conflict=0.
REQ-041 m0 write only -> mem_wen=1 one cycle, m0_rvalid stays 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared constants for the DATAMEM arbiter: default widths, port indices,
// performance counter width and a saturating-increment helper.
// The optional counters are enabled with MEM_ARB_PERF_EN.
package mem_arb_pkg;

  localparam int DEF_AW = 9;
  localparam int DEF_DW = 32;

  localparam int PORT_CPU = 0;
  localparam int PORT_LD  = 1;
  localparam int N_PORTS  = 2;

  localparam int CNT_W = 16;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin arbiter. Grants are combinational; the priority
// pointer only moves on cycles where both ports request, and then it moves
// to the port that lost, so a held request waits at most one cycle.
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic ptr_reg;
  logic ptr_next;

  // Grant selection and next pointer
  always_comb begin
    gnt      = req;
    ptr_next = ptr_reg;
    if (req == 2'b11) begin
      gnt          = 2'b00;
      gnt[ptr_reg] = 1'b1;
      ptr_next     = ~ptr_reg;
    end
  end

  // Priority pointer register; the CPU port has priority out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_reg <= 1'(PORT_CPU);
    else        ptr_reg <= ptr_next;
  end

endmodule

// File: rtl/mem_arb.sv
// DATAMEM arbiter between the CPU data port (m0) and the loader/test port
// (m1): one access per cycle, round-robin on conflict, registered read
// return with a one-cycle rvalid pulse to the owning port.
// Defining MEM_ARB_PERF_EN adds saturating grant/conflict counters.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
  output logic          stall
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_gnt0,
  output logic [CNT_W-1:0] perf_gnt1,
  output logic [CNT_W-1:0] perf_conflict
`endif
);

  logic [N_PORTS-1:0] req_vec;
  logic [N_PORTS-1:0] we_vec;
  logic [N_PORTS-1:0] gnt_vec;
  logic [AW-1:0]      addr_vec  [N_PORTS];
  logic [DW-1:0]      wdata_vec [N_PORTS];
  logic [N_PORTS-1:0] rvalid_reg;
  logic [DW-1:0]      rdata_reg [N_PORTS];

  // Requests are masked while reset is asserted so nothing is granted and
  // no write can reach the memory during reset
  assign req_vec      = {m1_req, m0_req} & {N_PORTS{rst_n}};
  assign we_vec       = {m1_we, m0_we};
  assign addr_vec[0]  = m0_addr;
  assign addr_vec[1]  = m1_addr;
  assign wdata_vec[0] = m0_wdata;
  assign wdata_vec[1] = m1_wdata;

  arb_rr2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_vec),
    .gnt   (gnt_vec)
  );

  assign m0_gnt    = gnt_vec[PORT_CPU];
  assign m1_gnt    = gnt_vec[PORT_LD];
  assign stall     = m0_req & ~m0_gnt;
  assign m0_rvalid = rvalid_reg[PORT_CPU];
  assign m1_rvalid = rvalid_reg[PORT_LD];
  assign m0_rdata  = rdata_reg[PORT_CPU];
  assign m1_rdata  = rdata_reg[PORT_LD];

  // Memory-side mux: the granted port drives the bus, idle bus is all zero
  always_comb begin
    mem_wen  = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (gnt_vec[i]) begin
        mem_wen  = we_vec[i];
        mem_addr = addr_vec[i];
        mem_din  = wdata_vec[i];
      end
    end
  end

  // Read return: capture mem_dout on a granted read, pulse rvalid next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_reg <= '0;
      for (int i = 0; i < N_PORTS; i++) rdata_reg[i] <= '0;
    end else begin
      for (int i = 0; i < N_PORTS; i++) begin
        rvalid_reg[i] <= gnt_vec[i] & ~we_vec[i];
        if (gnt_vec[i] && !we_vec[i]) rdata_reg[i] <= mem_dout;
      end
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic [CNT_W-1:0] cnt_gnt0_reg;
  logic [CNT_W-1:0] cnt_gnt1_reg;
  logic [CNT_W-1:0] cnt_conflict_reg;

  // Saturating grant and conflict counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_gnt0_reg     <= '0;
      cnt_gnt1_reg     <= '0;
      cnt_conflict_reg <= '0;
    end else begin
      if (gnt_vec[PORT_CPU]) cnt_gnt0_reg     <= sat_inc(cnt_gnt0_reg);
      if (gnt_vec[PORT_LD])  cnt_gnt1_reg     <= sat_inc(cnt_gnt1_reg);
      if (&req_vec)          cnt_conflict_reg <= sat_inc(cnt_conflict_reg);
    end
  end

  assign perf_gnt0     = cnt_gnt0_reg;
  assign perf_gnt1     = cnt_gnt1_reg;
  assign perf_conflict = cnt_conflict_reg;
`endif

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: directed scenarios plus a randomized run
// against a transaction-level model (shadow memory, priority owner, expected
// read returns). Counter checks run when MEM_ARB_PERF_EN is defined.
module tb_mem_arb;

  localparam int AW = 9;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          m0_req = 1'b0, m0_we = 1'b0;
  logic [AW-1:0] m0_addr = '0;
  logic [DW-1:0] m0_wdata = '0;
  logic          m0_gnt, m0_rvalid;
  logic [DW-1:0] m0_rdata;
  logic          m1_req = 1'b0, m1_we = 1'b0;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m1_wdata = '0;
  logic          m1_gnt, m1_rvalid;
  logic [DW-1:0] m1_rdata;
  logic          mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;
  logic          stall;
`ifdef MEM_ARB_PERF_EN
  logic [15:0]   perf_gnt0, perf_gnt1, perf_conflict;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Environment memory behind the arbiter
  logic [DW-1:0] tb_mem [2**AW];
  assign mem_dout = tb_mem[mem_addr];
  always @(posedge clk) if (mem_wen) tb_mem[mem_addr] = mem_din;

  always #5 clk = ~clk;

  mem_arb #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .stall(stall)
`ifdef MEM_ARB_PERF_EN
    , .perf_gnt0(perf_gnt0), .perf_gnt1(perf_gnt1), .perf_conflict(perf_conflict)
`endif
  );

  task automatic idle_inputs();
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    m0_req = 1; m0_we = 1; m0_addr = 9'h003; m0_wdata = 32'hAAAA_5555;
    m1_req = 1; m1_we = 1; m1_addr = 9'h007; m1_wdata = 32'h5555_AAAA;
    @(posedge clk); #2;
    n_checks++;
    if (mem_wen !== 1'b0) begin n_fail++; $display("FAIL reset_wen: got %b want 0", mem_wen); end
    n_checks++;
    if ({m0_gnt, m1_gnt} !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b want 00", {m0_gnt, m1_gnt}); end
    n_checks++;
    if ({m0_rvalid, m1_rvalid} !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid: got %b want 00", {m0_rvalid, m1_rvalid}); end
    n_checks++;
    if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_rdata: got %h/%h want 0/0", m0_rdata, m1_rdata);
    end
    $display("test_reset done");
  endtask

  task automatic test_single_read();
    apply_reset();
    tb_mem[9'h004] = 32'h1234_5678;
    m0_req = 1; m0_we = 0; m0_addr = 9'h004;
    #1;
    n_checks++;
    if (m0_gnt !== 1'b1 || stall !== 1'b0) begin
      n_fail++; $display("FAIL single_read_gnt: gnt=%b stall=%b want 1/0", m0_gnt, stall);
    end
    step();
    m0_req = 0;
    #1;
    n_checks++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h1234_5678) begin
      n_fail++; $display("FAIL single_read_data: rvalid=%b rdata=%h want 1/12345678", m0_rvalid, m0_rdata);
    end
    step();
    n_checks++;
    if (m0_rvalid !== 1'b0 || m0_rdata !== 32'h1234_5678) begin
      n_fail++; $display("FAIL single_read_hold: rvalid=%b rdata=%h want 0/12345678", m0_rvalid, m0_rdata);
    end
    $display("test_single_read done");
  endtask

  task automatic test_alternate();
    apply_reset();
    m0_req = 1; m0_addr = 9'h001;
    m1_req = 1; m1_addr = 9'h002;
    for (int c = 1; c <= 4; c++) begin
      #1;
      n_checks++;
      if (m0_gnt !== (c % 2 == 1) || m1_gnt !== (c % 2 == 0) || stall !== (c % 2 == 0)) begin
        n_fail++;
        $display("FAIL alternate_c%0d: gnt0=%b gnt1=%b stall=%b want %b/%b/%b",
                 c, m0_gnt, m1_gnt, stall, c % 2 == 1, c % 2 == 0, c % 2 == 0);
      end
      step();
    end
    idle_inputs();
    $display("test_alternate done");
  endtask

  task automatic test_hazard();
    apply_reset();
    tb_mem[9'h010] = 32'h0BAD_F00D;
    m0_req = 1; m0_addr = 9'h000;
    m1_req = 1; m1_addr = 9'h001;
    #1;
    n_checks++;
    if (m0_gnt !== 1'b1) begin n_fail++; $display("FAIL hazard_setup: gnt0=%b want 1", m0_gnt); end
    step();
    m0_req = 1; m0_we = 0; m0_addr = 9'h010;
    m1_req = 1; m1_we = 1; m1_addr = 9'h010; m1_wdata = 32'hDEAD_BEEF;
    #1;
    n_checks++;
    if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0 || mem_wen !== 1'b1) begin
      n_fail++; $display("FAIL hazard_first: gnt1=%b gnt0=%b wen=%b want 1/0/1", m1_gnt, m0_gnt, mem_wen);
    end
    step();
    m1_req = 0; m1_we = 0;
    #1;
    n_checks++;
    if (m0_gnt !== 1'b1) begin n_fail++; $display("FAIL hazard_second: gnt0=%b want 1", m0_gnt); end
    step();
    m0_req = 0;
    #1;
    n_checks++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hDEAD_BEEF || m1_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL hazard_data: rvalid=%b rdata=%h rvalid1=%b want 1/deadbeef/0", m0_rvalid, m0_rdata, m1_rvalid);
    end
    step();
    $display("test_hazard done");
  endtask

  task automatic test_reset_mid_read();
    apply_reset();
    // Move priority to port 1 first so reset is seen to restore it
    m0_req = 1; m1_req = 1;
    step();
    m1_req = 0;
    tb_mem[9'h004] = 32'h1234_5678;
    m0_addr = 9'h004;
    step();
    idle_inputs();
    rst_n = 0;
    #1;
    n_checks++;
    if (m0_rvalid !== 1'b0 || m0_rdata !== 32'h0) begin
      n_fail++; $display("FAIL midread_reset: rvalid=%b rdata=%h want 0/0", m0_rvalid, m0_rdata);
    end
    @(posedge clk); #1 rst_n = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
        n_fail++; $display("FAIL midread_norvalid_%0d: rvalid=%b%b want 00", c, m0_rvalid, m1_rvalid);
      end
      step();
    end
    m0_req = 1; m1_req = 1;
    #1;
    n_checks++;
    if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
      n_fail++; $display("FAIL midread_ptr: gnt0=%b gnt1=%b want 1/0", m0_gnt, m1_gnt);
    end
    step();
    idle_inputs();
    $display("test_reset_mid_read done");
  endtask

  task automatic test_write_only();
    apply_reset();
    m0_req = 1; m0_we = 1; m0_addr = 9'h005; m0_wdata = 32'hCAFE_0123;
    #1;
    n_checks++;
    if (mem_wen !== 1'b1 || mem_addr !== 9'h005 || mem_din !== 32'hCAFE_0123) begin
      n_fail++; $display("FAIL write_bus: wen=%b addr=%h din=%h want 1/005/cafe0123", mem_wen, mem_addr, mem_din);
    end
    step();
    idle_inputs();
    #1;
    n_checks++;
    if (mem_wen !== 1'b0 || m0_rvalid !== 1'b0 || mem_addr !== '0 || tb_mem[5] !== 32'hCAFE_0123) begin
      n_fail++; $display("FAIL write_after: wen=%b rvalid=%b addr=%h mem5=%h want 0/0/000/cafe0123",
                         mem_wen, m0_rvalid, mem_addr, tb_mem[5]);
    end
    step();
    n_checks++;
    if (m0_rvalid !== 1'b0) begin n_fail++; $display("FAIL write_norvalid: rvalid=%b want 0", m0_rvalid); end
    $display("test_write_only done");
  endtask

  task automatic test_random();
    logic [DW-1:0] ref_mem [2**AW];
    int            ref_owner;           // port that wins the next conflict
    bit            r_req [2], r_we [2], pend [2];
    logic [AW-1:0] r_addr [2];
    logic [DW-1:0] r_wd [2];
    bit            exp_rv [2];
    logic [DW-1:0] exp_rd [2];
    int            win;
    apply_reset();
    for (int a = 0; a < 2**AW; a++) begin
      ref_mem[a] = $urandom;
      tb_mem[a]  = ref_mem[a];
    end
    ref_owner = 0;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 0; exp_rv[p] = 0; exp_rd[p] = '0; r_req[p] = 0; r_we[p] = 0;
      r_addr[p] = '0; r_wd[p] = '0;
    end
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p]) begin
          r_req[p]  = ($urandom_range(0, 99) < 60);
          r_we[p]   = $urandom_range(0, 1) == 1;
          r_addr[p] = AW'($urandom_range(0, 15));
          r_wd[p]   = $urandom;
        end
      end
      m0_req = r_req[0]; m0_we = r_we[0]; m0_addr = r_addr[0]; m0_wdata = r_wd[0];
      m1_req = r_req[1]; m1_we = r_we[1]; m1_addr = r_addr[1]; m1_wdata = r_wd[1];
      #1;
      if (r_req[0] && r_req[1]) win = ref_owner;
      else if (r_req[0])        win = 0;
      else if (r_req[1])        win = 1;
      else                      win = -1;
      n_checks++;
      if (m0_gnt !== (win == 0) || m1_gnt !== (win == 1) || stall !== (r_req[0] && win != 0)) begin
        n_fail++; $display("FAIL rand_gnt c%0d: gnt=%b%b stall=%b want winner %0d", cyc, m1_gnt, m0_gnt, stall, win);
      end
      n_checks++;
      if (win >= 0) begin
        if (mem_wen !== r_we[win] || mem_addr !== r_addr[win] || mem_din !== r_wd[win]) begin
          n_fail++; $display("FAIL rand_bus c%0d: wen=%b addr=%h din=%h want %b/%h/%h",
                             cyc, mem_wen, mem_addr, mem_din, r_we[win], r_addr[win], r_wd[win]);
        end
      end else if (mem_wen !== 1'b0 || mem_addr !== '0 || mem_din !== '0) begin
        n_fail++; $display("FAIL rand_idle c%0d: wen=%b addr=%h din=%h want 0/0/0", cyc, mem_wen, mem_addr, mem_din);
      end
      n_checks++;
      if (m0_rvalid !== exp_rv[0] || m1_rvalid !== exp_rv[1] || m0_rdata !== exp_rd[0] || m1_rdata !== exp_rd[1]) begin
        n_fail++; $display("FAIL rand_read c%0d: rv=%b%b rd0=%h rd1=%h want %b%b %h %h", cyc,
                           m1_rvalid, m0_rvalid, m0_rdata, m1_rdata, exp_rv[1], exp_rv[0], exp_rd[0], exp_rd[1]);
      end
      // Model the effect of this cycle's access
      exp_rv[0] = 0; exp_rv[1] = 0;
      if (r_req[0] && r_req[1]) ref_owner = 1 - win;
      if (win >= 0) begin
        if (r_we[win]) ref_mem[r_addr[win]] = r_wd[win];
        else begin
          exp_rv[win] = 1;
          exp_rd[win] = ref_mem[r_addr[win]];
        end
      end
      for (int p = 0; p < 2; p++) pend[p] = r_req[p] && (win != p);
      step();
    end
    idle_inputs();
    $display("test_random done");
  endtask

`ifdef MEM_ARB_PERF_EN
  task automatic test_perf();
    apply_reset();
    n_checks++;
    if (perf_gnt0 !== 16'h0 || perf_gnt1 !== 16'h0 || perf_conflict !== 16'h0) begin
      n_fail++; $display("FAIL perf_reset: %h/%h/%h want 0/0/0", perf_gnt0, perf_gnt1, perf_conflict);
    end
    m0_req = 1; m0_we = 0; m0_addr = 9'h004;
    for (int c = 0; c < 70000; c++) step();
    idle_inputs();
    #1;
    n_checks++;
    if (perf_gnt0 !== 16'hFFFF || perf_gnt1 !== 16'h0 || perf_conflict !== 16'h0) begin
      n_fail++; $display("FAIL perf_sat: %h/%h/%h want ffff/0/0", perf_gnt0, perf_gnt1, perf_conflict);
    end
    $display("test_perf done");
  endtask
`endif

  initial begin
    test_reset();
    test_single_read();
    test_alternate();
    test_hazard();
    test_reset_mid_read();
    test_write_only();
    test_random();
`ifdef MEM_ARB_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
